dccm_arbiter: RTL and testbench

DCCM_ARBITER -- requirements
Module: dccm_arbiter

---
 rtl/dccm_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dccm_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dccm_arbiter.sv
// ---------------------------------------------------------------------------
// dccm_arbiter
//
// Shares one single-ported DCCM between the core and a DMA engine. At most
// one access is issued per cycle. The core normally wins, but a pending DMA
// request is forced through after STARVE_LIMIT consecutive core grants. The
// DMA can also lock the memory for a burst by holding dma_lock. While the DMA
// owns the memory, the core is stalled.
//
// Read data comes back one cycle after the read strobe. It is routed to the
// port that was granted that read.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   core_req/we/addr/wdata core request channel
//   core_gnt              core access accepted this cycle
//   core_rvalid/rdata     core read return (one cycle after its read grant)
//   dma_req/we/addr/wdata DMA request channel
//   dma_lock              DMA keeps ownership after this grant (burst)
//   dma_gnt               DMA access accepted this cycle
//   dma_rvalid/rdata      DMA read return (one cycle after its read grant)
//   dccm_wr_en/addr/data  memory write port (zeroed when not writing)
//   dccm_rd_en/addr       memory read port (zeroed when not reading)
//   dccm_rd_data          memory read data, valid the cycle after dccm_rd_en
// ---------------------------------------------------------------------------
module dccm_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dccm_wr_en,
  output logic        dccm_rd_en,
  output logic [31:0] dccm_wr_addr,
  output logic [31:0] dccm_rd_addr,
  output logic [31:0] dccm_wr_data,
  input  logic [31:0] dccm_rd_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {
    ARB,
    DMA_OWN
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_DMA
  } owner_t;

  state_t      state;
  owner_t      rd_owner;
  logic [3:0]  starve_cnt;

  logic        core_win;
  logic        dma_win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Winner selection. The grants are gated by rst_n so that every grant and
  // strobe drops immediately when reset is asserted, not at the next edge.
  // In DMA_OWN only the DMA can win. In ARB the core wins unless the DMA has
  // been waiting through STARVE_LIMIT core grants.
  always_comb begin
    core_win = 1'b0;
    dma_win  = 1'b0;
    if (rst_n) begin
      if (state == DMA_OWN) begin
        dma_win = dma_req;
      end else if (core_req && !(dma_req && (starve_cnt == LIMIT))) begin
        core_win = 1'b1;
      end else if (dma_req) begin
        dma_win = 1'b1;
      end
    end
  end

  // Memory port steering. The winner's request drives either the write port
  // or the read port. Unused address/data outputs are forced to zero so the
  // memory never sees stale values.
  always_comb begin
    sel_we       = dma_win ? dma_we    : core_we;
    sel_addr     = dma_win ? dma_addr  : core_addr;
    sel_wdata    = dma_win ? dma_wdata : core_wdata;
    dccm_wr_en   = (core_win || dma_win) && sel_we;
    dccm_rd_en   = (core_win || dma_win) && !sel_we;
    dccm_wr_addr = dccm_wr_en ? sel_addr  : 32'h0;
    dccm_wr_data = dccm_wr_en ? sel_wdata : 32'h0;
    dccm_rd_addr = dccm_rd_en ? sel_addr  : 32'h0;
  end

  assign core_gnt = core_win;
  assign dma_gnt  = dma_win;

  // Read return. The owner is registered when a read is granted, so the data
  // arriving next cycle goes to the right port. The other port sees zeros.
  always_comb begin
    core_rvalid = (rd_owner == OWN_CORE);
    dma_rvalid  = (rd_owner == OWN_DMA);
    core_rdata  = core_rvalid ? dccm_rd_data : 32'h0;
    dma_rdata   = dma_rvalid  ? dccm_rd_data : 32'h0;
  end

  // Arbiter state. The lock is dropped after the DMA takes a grant without
  // dma_lock, or as soon as the DMA stops requesting (burst abandoned). The
  // starvation counter only runs while the DMA is actually waiting. It never
  // passes LIMIT, because a core grant at LIMIT can only happen while the
  // DMA is idle, and that clears the counter anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      starve_cnt <= 4'd0;
      rd_owner   <= OWN_NONE;
    end else begin
      case (state)
        ARB: begin
          if (dma_win && dma_lock) begin
            state <= DMA_OWN;
          end
        end
        DMA_OWN: begin
          if (!dma_req || (dma_win && !dma_lock)) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase

      if (dma_win || !dma_req) begin
        starve_cnt <= 4'd0;
      end else if (core_win && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (dccm_rd_en) begin
        rd_owner <= core_win ? OWN_CORE : OWN_DMA;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

endmodule

// File: tb/tb_dccm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dccm_arbiter
//
// Directed bench for dccm_arbiter with the default STARVE_LIMIT of 4. Each
// step drives one cycle of requests and the memory read data. It then checks
// the combinational grant/strobe outputs, and the read return belonging to
// the previous cycle's grant. Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_dccm_arbiter;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_gnt;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_lock;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dccm_wr_en;
  logic        dccm_rd_en;
  logic [31:0] dccm_wr_addr;
  logic [31:0] dccm_rd_addr;
  logic [31:0] dccm_wr_data;
  logic [31:0] dccm_rd_data;

  int testCount = 0;
  int failCount = 0;

  dccm_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_gnt     (core_gnt),
    .core_rvalid  (core_rvalid),
    .core_rdata   (core_rdata),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_lock     (dma_lock),
    .dma_gnt      (dma_gnt),
    .dma_rvalid   (dma_rvalid),
    .dma_rdata    (dma_rdata),
    .dccm_wr_en   (dccm_wr_en),
    .dccm_rd_en   (dccm_rd_en),
    .dccm_wr_addr (dccm_wr_addr),
    .dccm_rd_addr (dccm_rd_addr),
    .dccm_wr_data (dccm_wr_data),
    .dccm_rd_data (dccm_rd_data)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of request inputs plus the memory read data, then let
  // the combinational outputs settle.
  task automatic applyStimulus(
    input logic        cReq,
    input logic        cWe,
    input logic [31:0] cAddr,
    input logic [31:0] cWdata,
    input logic        dReq,
    input logic        dWe,
    input logic [31:0] dAddr,
    input logic [31:0] dWdata,
    input logic        dLock,
    input logic [31:0] memData
  );
    core_req     = cReq;
    core_we      = cWe;
    core_addr    = cAddr;
    core_wdata   = cWdata;
    dma_req      = dReq;
    dma_we       = dWe;
    dma_addr     = dAddr;
    dma_wdata    = dWdata;
    dma_lock     = dLock;
    dccm_rd_data = memData;
    #1;
  endtask

  // One comparison: count it, and report tag/observed/expected on a miss
  task automatic checkOutput(
    input string       tag,
    input logic [31:0] observed,
    input logic [31:0] expected
  );
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          expCnt [9] = '{2, 3, 4, 0, 1, 2, 3, 4, 0};
    logic [8:0]  dmaPattern;
    logic        lastWasDma;
    logic        lastWasRead;
    logic        expCoreRv;
    logic        expDmaRv;

    dmaPattern = 9'b1_0000_1000;

    // Reset: a core request must not be granted while rst_n is low
    rst_n = 1'b0;
    applyStimulus(1, 0, 32'h100, 0, 1, 0, 32'h300, 0, 0, 32'h12345678);
    checkOutput("rst core_gnt", core_gnt, 0);
    checkOutput("rst dma_gnt", dma_gnt, 0);
    checkOutput("rst rd_en", dccm_rd_en, 0);
    checkOutput("rst rd_addr", dccm_rd_addr, 0);
    checkOutput("rst core_rvalid", core_rvalid, 0);
    checkOutput("rst core_rdata", core_rdata, 0);
    #10;
    rst_n = 1'b1;
    nextCycle();

    // Core read 0x100, memory answers 0xDEADBEEF one cycle later
    applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd core_gnt", core_gnt, 1);
    checkOutput("rd dma_gnt", dma_gnt, 0);
    checkOutput("rd rd_en", dccm_rd_en, 1);
    checkOutput("rd wr_en", dccm_wr_en, 0);
    checkOutput("rd rd_addr", dccm_rd_addr, 32'h100);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    checkOutput("rd core_rvalid", core_rvalid, 1);
    checkOutput("rd core_rdata", core_rdata, 32'hDEADBEEF);
    checkOutput("rd dma_rvalid", dma_rvalid, 0);
    checkOutput("rd dma_rdata", dma_rdata, 0);
    checkOutput("idle core_gnt", core_gnt, 0);
    checkOutput("idle rd_addr", dccm_rd_addr, 0);

    // Core write against a DMA read: the core wins and starve_cnt goes 0->1
    applyStimulus(1, 1, 32'h200, 32'h11112222, 1, 0, 32'h300, 0, 0, 0);
    checkOutput("cw core_gnt", core_gnt, 1);
    checkOutput("cw dma_gnt", dma_gnt, 0);
    checkOutput("cw wr_en", dccm_wr_en, 1);
    checkOutput("cw rd_en", dccm_rd_en, 0);
    checkOutput("cw wr_addr", dccm_wr_addr, 32'h200);
    checkOutput("cw wr_data", dccm_wr_data, 32'h11112222);
    nextCycle();
    checkOutput("cw starve_cnt", dut.starve_cnt, 1);

    // Both keep reading: counter continues 2,3,4 then DMA, then C,C,C,C,D.
    // Each read returns its own data on the following cycle.
    lastWasDma  = 1'b0;
    lastWasRead = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 32'h10 + 32'(4 * i), 0, 1, 0, 32'h300, 0, 0,
                    32'hA0000000 + 32'(i));
      expCoreRv = lastWasRead && !lastWasDma;
      expDmaRv  = lastWasRead && lastWasDma;
      checkOutput("starve dma_gnt", dma_gnt, dmaPattern[i]);
      checkOutput("starve core_gnt", core_gnt, !dmaPattern[i]);
      checkOutput("starve rd_addr", dccm_rd_addr,
                  dmaPattern[i] ? 32'h300 : 32'h10 + 32'(4 * i));
      checkOutput("starve core_rvalid", core_rvalid, expCoreRv);
      checkOutput("starve dma_rvalid", dma_rvalid, expDmaRv);
      checkOutput("starve core_rdata", core_rdata,
                  expCoreRv ? 32'hA0000000 + 32'(i) : 32'h0);
      nextCycle();
      checkOutput("starve cnt", dut.starve_cnt, 32'(expCnt[i]));
      lastWasDma  = dmaPattern[i];
      lastWasRead = 1'b1;
    end

    // The last loop step was a DMA read, so its data comes back now
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555AAAA);
    checkOutput("tail dma_rvalid", dma_rvalid, 1);
    checkOutput("tail dma_rdata", dma_rdata, 32'h5555AAAA);
    checkOutput("tail core_rvalid", core_rvalid, 0);
    nextCycle();
    checkOutput("tail starve_cnt", dut.starve_cnt, 0);

    // Locked DMA write burst while the core keeps requesting. First starve
    // the DMA for 4 core writes so it wins, then lock 1,1,0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 32'h800, 32'(i), 1, 1, 32'h400, 32'hD0, 1, 0);
      checkOutput("pre core_gnt", core_gnt, 1);
      nextCycle();
    end
    applyStimulus(1, 1, 32'h800, 32'h4, 1, 1, 32'h400, 32'hD0, 1, 0);
    checkOutput("burst0 dma_gnt", dma_gnt, 1);
    checkOutput("burst0 core_gnt", core_gnt, 0);
    checkOutput("burst0 wr_addr", dccm_wr_addr, 32'h400);
    checkOutput("burst0 wr_data", dccm_wr_data, 32'hD0);
    nextCycle();
    applyStimulus(1, 1, 32'h800, 32'h5, 1, 1, 32'h404, 32'hD1, 1, 0);
    checkOutput("burst1 dma_gnt", dma_gnt, 1);
    checkOutput("burst1 core_gnt", core_gnt, 0);
    checkOutput("burst1 wr_addr", dccm_wr_addr, 32'h404);
    nextCycle();
    applyStimulus(1, 1, 32'h800, 32'h6, 1, 1, 32'h408, 32'hD2, 0, 0);
    checkOutput("burst2 dma_gnt", dma_gnt, 1);
    checkOutput("burst2 core_gnt", core_gnt, 0);
    checkOutput("burst2 wr_data", dccm_wr_data, 32'hD2);
    nextCycle();
    applyStimulus(1, 1, 32'h800, 32'h7, 0, 0, 0, 0, 0, 0);
    checkOutput("after core_gnt", core_gnt, 1);
    checkOutput("after dma_gnt", dma_gnt, 0);
    checkOutput("after wr_addr", dccm_wr_addr, 32'h800);
    nextCycle();

    // Alternating core/DMA reads: returns alternate one cycle later
    applyStimulus(1, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alt0 core_gnt", core_gnt, 1);
    checkOutput("alt0 rd_addr", dccm_rd_addr, 32'h500);
    checkOutput("alt0 core_rvalid", core_rvalid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h600, 0, 0, 32'h11110500);
    checkOutput("alt1 dma_gnt", dma_gnt, 1);
    checkOutput("alt1 rd_addr", dccm_rd_addr, 32'h600);
    checkOutput("alt1 core_rvalid", core_rvalid, 1);
    checkOutput("alt1 core_rdata", core_rdata, 32'h11110500);
    checkOutput("alt1 dma_rvalid", dma_rvalid, 0);
    nextCycle();
    applyStimulus(1, 0, 32'h504, 0, 0, 0, 0, 0, 0, 32'h22220600);
    checkOutput("alt2 core_gnt", core_gnt, 1);
    checkOutput("alt2 dma_rvalid", dma_rvalid, 1);
    checkOutput("alt2 dma_rdata", dma_rdata, 32'h22220600);
    checkOutput("alt2 core_rvalid", core_rvalid, 0);
    checkOutput("alt2 core_rdata", core_rdata, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h604, 0, 0, 32'h33330504);
    checkOutput("alt3 dma_gnt", dma_gnt, 1);
    checkOutput("alt3 core_rdata", core_rdata, 32'h33330504);
    checkOutput("alt3 dma_rvalid", dma_rvalid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44440604);
    checkOutput("alt4 dma_rdata", dma_rdata, 32'h44440604);
    checkOutput("alt4 core_rvalid", core_rvalid, 0);
    checkOutput("alt4 rd_en", dccm_rd_en, 0);
    nextCycle();

    // Reset in the middle of a locked burst with a DMA read outstanding
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h900, 0, 1, 0);
    checkOutput("lock dma_gnt", dma_gnt, 1);
    nextCycle();
    applyStimulus(1, 0, 32'h700, 0, 1, 0, 32'h904, 0, 1, 32'hCAFEF00D);
    checkOutput("own core_gnt", core_gnt, 0);
    checkOutput("own dma_rvalid", dma_rvalid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst core_gnt", core_gnt, 0);
    checkOutput("arst dma_gnt", dma_gnt, 0);
    checkOutput("arst dma_rvalid", dma_rvalid, 0);
    checkOutput("arst dma_rdata", dma_rdata, 0);
    checkOutput("arst rd_en", dccm_rd_en, 0);
    checkOutput("arst rd_addr", dccm_rd_addr, 0);
    checkOutput("arst wr_en", dccm_wr_en, 0);
    @(posedge clk);
    #2;
    checkOutput("arst hold dma_gnt", dma_gnt, 0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 32'h700, 0, 0, 0, 0, 0, 0, 32'hBAD0BAD0);
    checkOutput("rel core_gnt", core_gnt, 1);
    checkOutput("rel rd_addr", dccm_rd_addr, 32'h700);
    checkOutput("rel dma_rvalid", dma_rvalid, 0);
    checkOutput("rel core_rvalid", core_rvalid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77770700);
    checkOutput("rel2 core_rvalid", core_rvalid, 1);
    checkOutput("rel2 core_rdata", core_rdata, 32'h77770700);
    checkOutput("rel2 dma_rvalid", dma_rvalid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99999999);
    checkOutput("rel3 core_rvalid", core_rvalid, 0);
    checkOutput("rel3 core_rdata", core_rdata, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
